// File: rtl/risc_ctrl_defs.sv
// Constants shared by the step sequencer and the Signal_* control decoders.
package risc_ctrl_defs;

  localparam int CNT_W_DEF = 3;

  localparam logic [4:0] OPM_SYS  = 5'b11100;
  localparam logic [1:0] OPL_HLT  = 2'b01;
  localparam logic [1:0] OPL_OUTR = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_t;

  function automatic logic is_hlt(input logic [4:0] opm, input logic [1:0] opl);
    return (opm == OPM_SYS) && (opl == OPL_HLT);
  endfunction

endpackage

// File: rtl/seq_step_counter.sv
// Step counter register with the last-legal-step compare.
module seq_step_counter #(
  parameter int CNT_W    = 3,
  parameter int MAX_STEP = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] Cnt,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEP);

  logic [CNT_W-1:0] cnt_reg;

  // Clear wins over increment so an instruction end always lands on step 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign Cnt    = cnt_reg;
  assign at_max = (cnt_reg == MAX_CNT);

endmodule

// File: rtl/multicycle_step_sequencer.sv
// Fetch/execute sequencer: step counter, latched opcode fields, HLT detection,
// retired-instruction count and sticky runaway-step flag.
module multicycle_step_sequencer
  import risc_ctrl_defs::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MAX_STEP = 7,
  parameter int RET_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             resume,
  input  logic [15:0]      ins_in,
  input  logic             ins_valid,
  input  logic             Buff_PC,
  output logic [CNT_W-1:0] Cnt,
  output logic [4:0]       InsM,
  output logic [1:0]       InsL,
  output logic             fetch_req,
  output logic             halted,
  output logic             step_err,
  output logic [RET_W-1:0] retired
);

  seq_state_t       state_reg;
  logic [4:0]       insm_reg;
  logic [1:0]       insl_reg;
  logic [RET_W-1:0] retired_reg;
  logic             fetch_req_reg;
  logic             halted_reg;
  logic             step_err_reg;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             at_max;

  always_comb begin
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    if (state_reg == ST_FETCH) begin
      cnt_inc = ins_valid;
    end else if (state_reg == ST_EXEC) begin
      cnt_clr = Buff_PC || at_max;
      cnt_inc = !Buff_PC && !at_max;
    end
  end

  seq_step_counter #(
    .CNT_W    (CNT_W),
    .MAX_STEP (MAX_STEP)
  ) u_step_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .Cnt    (Cnt),
    .at_max (at_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      insm_reg      <= '0;
      insl_reg      <= '0;
      retired_reg   <= '0;
      fetch_req_reg <= 1'b0;
      halted_reg    <= 1'b0;
      step_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (run) begin
            state_reg     <= ST_FETCH;
            fetch_req_reg <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (ins_valid) begin
            insm_reg      <= ins_in[15:11];
            insl_reg      <= ins_in[1:0];
            state_reg     <= ST_EXEC;
            fetch_req_reg <= 1'b0;
          end
        end
        ST_EXEC: begin
          // Completion on the last legal step is still a normal retire.
          if (Buff_PC) begin
            retired_reg <= retired_reg + RET_W'(1);
            if (is_hlt(insm_reg, insl_reg)) begin
              state_reg  <= ST_HALT;
              halted_reg <= 1'b1;
            end else begin
              state_reg     <= ST_FETCH;
              fetch_req_reg <= 1'b1;
            end
          end else if (at_max) begin
            step_err_reg <= 1'b1;
            state_reg    <= ST_HALT;
            halted_reg   <= 1'b1;
          end
        end
        ST_HALT: begin
          if (resume) begin
            state_reg     <= ST_FETCH;
            fetch_req_reg <= 1'b1;
            halted_reg    <= 1'b0;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          fetch_req_reg <= 1'b0;
          halted_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign InsM      = insm_reg;
  assign InsL      = insl_reg;
  assign fetch_req = fetch_req_reg;
  assign halted    = halted_reg;
  assign step_err  = step_err_reg;
  assign retired   = retired_reg;

endmodule

// File: tb/tb_multicycle_step_sequencer.sv
// Scoreboarded bench: a behavioural model pushes expected outputs per driven cycle,
// a monitor pops and compares them after each clock edge.
module tb_multicycle_step_sequencer;

  localparam int CNT_W    = 3;
  localparam int MAX_STEP = 7;
  localparam int RET_W    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run = 1'b0;
  logic             resume = 1'b0;
  logic [15:0]      ins_in = 16'h0000;
  logic             ins_valid = 1'b0;
  logic             Buff_PC = 1'b0;
  logic [CNT_W-1:0] Cnt;
  logic [4:0]       InsM;
  logic [1:0]       InsL;
  logic             fetch_req;
  logic             halted;
  logic             step_err;
  logic [RET_W-1:0] retired;

  multicycle_step_sequencer #(
    .CNT_W    (CNT_W),
    .MAX_STEP (MAX_STEP),
    .RET_W    (RET_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .resume    (resume),
    .ins_in    (ins_in),
    .ins_valid (ins_valid),
    .Buff_PC   (Buff_PC),
    .Cnt       (Cnt),
    .InsM      (InsM),
    .InsL      (InsL),
    .fetch_req (fetch_req),
    .halted    (halted),
    .step_err  (step_err),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [4:0]       insm;
    logic [1:0]       insl;
    logic             fr;
    logic             hl;
    logic             se;
    logic [RET_W-1:0] ret;
  } obs_t;

  obs_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  int               m_state;   // 0 idle, 1 fetch, 2 exec, 3 halt
  logic [CNT_W-1:0] m_cnt;
  logic [4:0]       m_insm;
  logic [1:0]       m_insl;
  logic             m_se;
  logic [RET_W-1:0] m_ret;

  task automatic model_reset();
    m_state = 0; m_cnt = '0; m_insm = '0; m_insl = '0; m_se = 1'b0; m_ret = '0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic r, input logic rs, input logic [15:0] ins,
                            input logic v, input logic b);
    case (m_state)
      0: if (r) m_state = 1;
      1: if (v) begin
           m_insm = ins[15:11]; m_insl = ins[1:0]; m_cnt = 3'd1; m_state = 2;
         end
      2: if (b) begin
           m_ret = m_ret + 2'd1; m_cnt = '0;
           m_state = (m_insm == 5'b11100 && m_insl == 2'b01) ? 3 : 1;
         end else if (m_cnt == 3'd7) begin
           m_se = 1'b1; m_cnt = '0; m_state = 3;
         end else begin
           m_cnt = m_cnt + 3'd1;
         end
      default: if (rs) m_state = 1;
    endcase
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.cnt = m_cnt; o.insm = m_insm; o.insl = m_insl;
    o.fr = (m_state == 1); o.hl = (m_state == 3); o.se = m_se; o.ret = m_ret;
    return o;
  endfunction

  // Drive one cycle of stimulus; returns 2 time units after the active edge.
  task automatic step(input logic r, input logic rs, input logic [15:0] ins,
                      input logic v, input logic b);
    run = r; resume = rs; ins_in = ins; ins_valid = v; Buff_PC = b;
    model_step(r, rs, ins, v, b);
    sb_q.push_back(model_obs());
    @(posedge clk);
    #2;
    run = 1'b0; resume = 1'b0; ins_valid = 1'b0; Buff_PC = 1'b0;
  endtask

  always @(posedge clk) begin
    obs_t got, exp_o;
    #1;
    if (rst_n && sb_q.size() > 0) begin
      exp_o = sb_q.pop_front();
      got   = '{Cnt, InsM, InsL, fetch_req, halted, step_err, retired};
      n_vec++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL scoreboard t=%0t got cnt=%0d insm=%b insl=%b fr=%b hl=%b se=%b ret=%0d required cnt=%0d insm=%b insl=%b fr=%b hl=%b se=%b ret=%0d",
                 $time, got.cnt, got.insm, got.insl, got.fr, got.hl, got.se, got.ret,
                 exp_o.cnt, exp_o.insm, exp_o.insl, exp_o.fr, exp_o.hl, exp_o.se, exp_o.ret);
      end else begin
        $display("vec t=%0t cnt=%0d insm=%b insl=%b fr=%b hl=%b se=%b ret=%0d",
                 $time, got.cnt, got.insm, got.insl, got.fr, got.hl, got.se, got.ret);
      end
    end
  end

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_vec++;
    if ({Cnt, InsM, InsL, fetch_req, halted, step_err, retired} !== '0) begin
      n_err++;
      $display("FAIL reset_state got cnt=%0d insm=%b insl=%b fr=%b hl=%b se=%b ret=%0d required all zero",
               Cnt, InsM, InsL, fetch_req, halted, step_err, retired);
    end
    rst_n = 1'b1;
    step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);  // resume ignored in IDLE
    n_vec++;
    if (fetch_req !== 1'b0) begin
      n_err++; $display("FAIL idle_resume_ignored fetch_req got %b required 0", fetch_req);
    end
  endtask

  task automatic test_add();
    logic [CNT_W-1:0] seq [5];
    logic [CNT_W-1:0] want [5];
    want[0] = 3'd0; want[1] = 3'd1; want[2] = 3'd2; want[3] = 3'd3; want[4] = 3'd0;
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    seq[0] = Cnt;
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    seq[1] = Cnt;
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    seq[2] = Cnt;
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    seq[3] = Cnt;
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    seq[4] = Cnt;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (seq[i] !== want[i]) begin
        n_err++; $display("FAIL add_cnt_seq[%0d] got %0d required %0d", i, seq[i], want[i]);
      end
    end
    n_vec++;
    if (retired !== 2'd1 || fetch_req !== 1'b1) begin
      n_err++; $display("FAIL add_retire got ret=%0d fr=%b required ret=1 fr=1", retired, fetch_req);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
      n_vec++;
      if (Cnt !== 3'd0 || InsM !== 5'b00000 || InsL !== 2'b00) begin
        n_err++;
        $display("FAIL stall_hold[%0d] got cnt=%0d insm=%b insl=%b required 0 00000 00", i, Cnt, InsM, InsL);
      end
    end
    step(1'b0, 1'b0, 16'h5A06, 1'b1, 1'b0);
    n_vec++;
    if (Cnt !== 3'd1 || InsM !== 5'b01011 || InsL !== 2'b10) begin
      n_err++;
      $display("FAIL stall_capture got cnt=%0d insm=%b insl=%b required 1 01011 10", Cnt, InsM, InsL);
    end
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
  endtask

  task automatic test_fetch_bpc_ignored();
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    n_vec++;
    if (retired !== 2'd2 || Cnt !== 3'd0 || fetch_req !== 1'b1) begin
      n_err++;
      $display("FAIL fetch_bpc got ret=%0d cnt=%0d fr=%b required 2 0 1", retired, Cnt, fetch_req);
    end
  endtask

  task automatic test_hlt_outr();
    step(1'b0, 1'b0, 16'hE001, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    n_vec++;
    if (halted !== 1'b1 || retired !== 2'd3 || Cnt !== 3'd0 || fetch_req !== 1'b0) begin
      n_err++;
      $display("FAIL hlt got hl=%b ret=%0d cnt=%0d fr=%b required 1 3 0 0", halted, retired, Cnt, fetch_req);
    end
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);  // run ignored in HALT
    n_vec++;
    if (halted !== 1'b1 || fetch_req !== 1'b0) begin
      n_err++; $display("FAIL halt_run_ignored got hl=%b fr=%b required 1 0", halted, fetch_req);
    end
    step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'hE000, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    n_vec++;
    if (halted !== 1'b0 || fetch_req !== 1'b1 || retired !== 2'd0) begin
      n_err++;
      $display("FAIL outr_no_halt got hl=%b fr=%b ret=%0d required 0 1 0", halted, fetch_req, retired);
    end
  endtask

  task automatic test_max_complete();
    step(1'b0, 1'b0, 16'h0800, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    n_vec++;
    if (Cnt !== 3'd7) begin
      n_err++; $display("FAIL max_reach got cnt=%0d required 7", Cnt);
    end
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    n_vec++;
    if (step_err !== 1'b0 || fetch_req !== 1'b1 || retired !== 2'd1) begin
      n_err++;
      $display("FAIL max_complete got se=%b fr=%b ret=%0d required 0 1 1", step_err, fetch_req, retired);
    end
  endtask

  task automatic test_runaway();
    step(1'b0, 1'b0, 16'h1003, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    n_vec++;
    if (step_err !== 1'b1 || halted !== 1'b1 || Cnt !== 3'd0 || retired !== 2'd1) begin
      n_err++;
      $display("FAIL runaway got se=%b hl=%b cnt=%0d ret=%0d required 1 1 0 1", step_err, halted, Cnt, retired);
    end
    step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    n_vec++;
    if (step_err !== 1'b1 || fetch_req !== 1'b1) begin
      n_err++; $display("FAIL runaway_sticky got se=%b fr=%b required 1 1", step_err, fetch_req);
    end
  endtask

  task automatic test_reset_mid_exec();
    step(1'b0, 1'b0, 16'h2002, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    n_vec++;
    if (Cnt !== 3'd3) begin
      n_err++; $display("FAIL pre_reset_cnt got %0d required 3", Cnt);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({Cnt, InsM, InsL, fetch_req, halted, step_err, retired} !== '0) begin
      n_err++;
      $display("FAIL async_reset got cnt=%0d insm=%b insl=%b fr=%b hl=%b se=%b ret=%0d required all zero",
               Cnt, InsM, InsL, fetch_req, halted, step_err, retired);
    end
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    n_vec++;
    if (fetch_req !== 1'b0 || Cnt !== 3'd0) begin
      n_err++; $display("FAIL post_reset_idle got fr=%b cnt=%0d required 0 0", fetch_req, Cnt);
    end
  endtask

  task automatic test_back_to_back_wrap();
    step(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);  // run wins over resume in IDLE
    n_vec++;
    if (fetch_req !== 1'b1) begin
      n_err++; $display("FAIL run_wins got fr=%b required 1", fetch_req);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 16'(i * 16'h0841), 1'b1, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    end
    n_vec++;
    if (retired !== 2'd1) begin
      n_err++; $display("FAIL retired_wrap got %0d required 1", retired);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_stall();
    test_fetch_bpc_ignored();
    test_hlt_outr();
    test_max_complete();
    test_runaway();
    test_reset_mid_exec();
    test_back_to_back_wrap();
    @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
